// File: rtl/apogee_tape_tx.sv
// apogee_tape_tx
//   Cassette-tape transmitter for the Apogee/RK-86 monitor tape-read routine.
//   Produces the biphase stream that feeds PPA port C bit 4 (the tape-input line
//   paired with the CPU's own tape-write bit on port C bit 0). A transfer sends
//   PILOT_BYTES bytes of 8'h00, then SYNC_BYTE, then the payload bytes taken
//   from a valid/ready byte interface, MSB first. Each bit is two halves:
//   first half ~bit, second half bit. All timing advances only on ce cycles.
//
// Ports
//   clk        system clock (clk_sys)
//   reset_n    asynchronous active-low reset
//   ce         timing enable (f2 strobe)
//   start      begin a transfer (only looked at while idle)
//   din        payload byte
//   din_valid  din is valid
//   din_last   din is the final payload byte
//   din_ready  block accepts din this cycle
//   tape_out   registered biphase tape level
//   busy       a transfer is in progress
//   done       one-clk pulse when a transfer completes
//   underrun   sticky: payload was not available at a byte boundary

module apogee_tape_tx #(
    parameter int unsigned HALF_TICKS  = 110,
    parameter int unsigned PILOT_BYTES = 256,
    parameter logic [7:0]  SYNC_BYTE   = 8'hE6,
    parameter logic        IDLE_LEVEL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       start,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic       tape_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int TW = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX   = TW'(HALF_TICKS - 1);
    localparam logic [15:0]   PILOT_INIT = 16'(PILOT_BYTES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PILOT = 2'd1;
    localparam logic [1:0] ST_SYNC  = 2'd2;
    localparam logic [1:0] ST_DATA  = 2'd3;

    logic [1:0]    state_reg;
    logic [7:0]    shift_reg;
    logic [15:0]   pilot_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic          half_reg;
    logic [TW-1:0] tick_reg;
    logic          tape_reg;
    logic [7:0]    hold_reg;
    logic          hold_full_reg;
    logic          last_seen_reg;
    logic          cur_last_reg;   // byte currently in shift_reg is the final one
    logic          stall_reg;      // frozen at a byte boundary waiting for payload
    logic          done_reg;
    logic          underrun_reg;

    logic accept;
    logic half_end;
    logic byte_end;
    logic finish;
    logic need_payload;
    logic load_payload;
    logic enter_stall;

    assign busy      = (state_reg != ST_IDLE);
    assign din_ready = busy & ~hold_full_reg & ~last_seen_reg;
    assign tape_out  = tape_reg;
    assign done      = done_reg;
    assign underrun  = underrun_reg;

    always_comb begin
        accept       = din_valid & din_ready;
        half_end     = busy & ce & ~stall_reg & (tick_reg == TICK_MAX);
        byte_end     = half_end & half_reg & (bit_idx_reg == 3'd0);
        finish       = byte_end & (state_reg == ST_DATA) & cur_last_reg;
        need_payload = byte_end & ((state_reg == ST_SYNC) |
                                   ((state_reg == ST_DATA) & ~cur_last_reg));
        // A stalled boundary retries on every ce cycle; the byte accepted on
        // the previous edge is visible in the holding register by then.
        load_payload = (need_payload | (stall_reg & ce)) & hold_full_reg;
        enter_stall  = need_payload & ~hold_full_reg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= 8'h00;
            pilot_cnt_reg <= 16'h0000;
            bit_idx_reg   <= 3'd7;
            half_reg      <= 1'b0;
            tick_reg      <= '0;
            tape_reg      <= IDLE_LEVEL;
            hold_reg      <= 8'h00;
            hold_full_reg <= 1'b0;
            last_seen_reg <= 1'b0;
            cur_last_reg  <= 1'b0;
            stall_reg     <= 1'b0;
            done_reg      <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            // Handshake runs independently of ce; it can never coincide with
            // consumption because ready requires an empty holding register.
            if (accept) begin
                hold_reg      <= din;
                hold_full_reg <= 1'b1;
                last_seen_reg <= din_last;
            end

            if (state_reg == ST_IDLE) begin
                if (start) begin
                    state_reg     <= ST_PILOT;
                    shift_reg     <= 8'h00;
                    pilot_cnt_reg <= PILOT_INIT;
                    bit_idx_reg   <= 3'd7;
                    half_reg      <= 1'b0;
                    tick_reg      <= '0;
                    tape_reg      <= 1'b1;      // first half of a 0 bit
                    underrun_reg  <= 1'b0;
                    stall_reg     <= 1'b0;
                    hold_full_reg <= 1'b0;
                    last_seen_reg <= 1'b0;
                    cur_last_reg  <= 1'b0;
                end
            end else if (finish) begin
                state_reg <= ST_IDLE;
                tape_reg  <= IDLE_LEVEL;
                done_reg  <= 1'b1;
                tick_reg  <= '0;
                half_reg  <= 1'b0;
            end else if (load_payload) begin
                state_reg     <= ST_DATA;
                shift_reg     <= hold_reg;
                hold_full_reg <= 1'b0;
                cur_last_reg  <= last_seen_reg;
                bit_idx_reg   <= 3'd7;
                half_reg      <= 1'b0;
                tick_reg      <= '0;
                stall_reg     <= 1'b0;
                tape_reg      <= ~hold_reg[7];
            end else if (enter_stall) begin
                // tape_reg keeps the second-half level of the finished bit.
                stall_reg    <= 1'b1;
                underrun_reg <= 1'b1;
                tick_reg     <= '0;
                half_reg     <= 1'b0;
            end else if (byte_end) begin
                // Only PILOT byte boundaries reach here.
                if (pilot_cnt_reg != 16'h0000) begin
                    pilot_cnt_reg <= pilot_cnt_reg - 16'd1;
                    shift_reg     <= 8'h00;
                    tape_reg      <= 1'b1;
                end else begin
                    state_reg <= ST_SYNC;
                    shift_reg <= SYNC_BYTE;
                    tape_reg  <= ~SYNC_BYTE[7];
                end
                bit_idx_reg <= 3'd7;
                half_reg    <= 1'b0;
                tick_reg    <= '0;
            end else if (half_end) begin
                tick_reg <= '0;
                if (!half_reg) begin
                    half_reg <= 1'b1;
                    tape_reg <= shift_reg[7];
                end else begin
                    half_reg    <= 1'b0;
                    bit_idx_reg <= bit_idx_reg - 3'd1;
                    shift_reg   <= {shift_reg[6:0], 1'b0};
                    tape_reg    <= ~shift_reg[6];
                end
            end else if (ce & ~stall_reg) begin
                tick_reg <= tick_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apogee_tape_tx.sv
module tb_apogee_tape_tx;

    localparam int HT = 4;
    localparam int PB = 2;
    localparam logic [7:0] SYNC = 8'hE6;
    // pilot + sync + one payload byte, 16 halves per byte
    localparam int STREAM_HALVES = (PB + 2) * 16;
    localparam int B1 = STREAM_HALVES * HT;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       start;
    logic [7:0] din;
    logic       din_valid;
    logic       din_last;
    logic       din_ready;
    logic       tape_out;
    logic       busy;
    logic       done;
    logic       underrun;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    apogee_tape_tx #(
        .HALF_TICKS (HT),
        .PILOT_BYTES(PB),
        .SYNC_BYTE  (SYNC),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .start    (start),
        .din      (din),
        .din_valid(din_valid),
        .din_last (din_last),
        .din_ready(din_ready),
        .tape_out (tape_out),
        .busy     (busy),
        .done     (done),
        .underrun (underrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) begin
            exp_q.push_back(~v[b]);
            exp_q.push_back(v[b]);
        end
    endfunction

    function automatic void build_head();
        exp_q.delete();
        for (int p = 0; p < PB; p++) push_byte(8'h00);
        push_byte(SYNC);
    endfunction

    // One full transfer of a single last payload byte, checked every clk.
    task automatic run_stream(input int period, input logic [7:0] pay,
                              input bit hold_valid, input bit poke_start);
        int total;
        build_head();
        push_byte(pay);
        total = STREAM_HALVES * HT * period;
        ce = 1'b1; din = pay; din_last = 1'b1; din_valid = hold_valid; start = 1'b0;
        if (hold_valid) begin
            for (int k = 0; k < 3; k++) begin
                step();
                chk("idle_ready", din_ready, 0);
                chk("idle_busy", busy, 0);
            end
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_underrun_clr", underrun, 0);
        chk("first_ready", din_ready, 1);
        for (int i = 0; i < total; i++) begin
            ce = ((i % period) == (period - 1));
            din_valid = hold_valid || (i == 0);
            start = poke_start && (i == 10);
            chk("tape", tape_out, exp_q[i / (HT * period)]);
            chk("busy_run", busy, 1);
            if (i > 0) chk("ready_closed", din_ready, 0);
            step();
        end
        start = 1'b0; din_valid = 1'b0; ce = 1'b1;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_tape", tape_out, 0);
        chk("end_ready", din_ready, 0);
        chk("end_underrun", underrun, 0);
        step();
        chk("done_pulse_len", done, 0);
        $display("xfer: period=%0d payload=%02h halves=%0d clks=%0d", period, pay, STREAM_HALVES, total);
    endtask

    initial begin
        logic e;
        reset_n = 1'b0; ce = 1'b1; start = 1'b0; din = 8'h00; din_valid = 1'b0; din_last = 1'b0;
        step(); step();
        chk("rst_tape", tape_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", din_ready, 0);
        chk("rst_underrun", underrun, 0);
        reset_n = 1'b1;
        step();
        chk("idle_busy0", busy, 0);

        // Basic stream, ce every clk, then ce every 3rd clk.
        run_stream(1, 8'hA5, 1'b0, 1'b0);
        run_stream(3, 8'hA5, 1'b0, 1'b0);

        // Underrun: 3C then FF, second byte withheld past 3C's boundary.
        build_head();
        push_byte(8'h3C);
        push_byte(8'hFF);
        ce = 1'b1; din = 8'h3C; din_last = 1'b0; din_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < B1 + 52 + 16 * HT; i++) begin
            din_valid = (i == 0) || (i == B1 + 50);
            din = (i < B1 + 44) ? 8'h3C : 8'hFF;
            din_last = (i >= B1 + 44);
            if (i < B1) e = exp_q[i / HT];
            else if (i < B1 + 52) e = 1'b0;
            else e = exp_q[STREAM_HALVES + (i - B1 - 52) / HT];
            chk("stall_tape", tape_out, e);
            if (i < B1) chk("pre_underrun", underrun, 0);
            if (i >= B1 && i <= B1 + 50) begin
                chk("stall_underrun", underrun, 1);
                chk("stall_ready", din_ready, 1);
            end
            step();
        end
        din_valid = 1'b0;
        chk("stall_done", done, 1);
        chk("stall_end_busy", busy, 0);
        chk("stall_end_tape", tape_out, 0);
        chk("underrun_sticky", underrun, 1);
        step();
        chk("stall_done_len", done, 0);
        chk("underrun_sticky2", underrun, 1);
        $display("xfer: stall payload=3C,FF resume_at=%0d", B1 + 52);

        // Start poked during pilot, din_valid held high idle and after last.
        run_stream(1, 8'h00, 1'b1, 1'b1);

        // Asynchronous reset mid-DATA.
        ce = 1'b1; din = 8'h55; din_last = 1'b1; din_valid = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 205; i++) begin
            din_valid = (i == 0);
            step();
        end
        din_valid = 1'b0;
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_tape", tape_out, 1);
        reset_n = 1'b0;
        #1;
        chk("async_tape", tape_out, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", din_ready, 0);
        chk("async_done", done, 0);
        step();
        chk("rst_hold_done", done, 0);
        step();
        chk("rst_hold_busy", busy, 0);
        reset_n = 1'b1;
        step();
        chk("post_rst_done", done, 0);
        $display("xfer: reset mid-data payload=55");
        run_stream(1, 8'h81, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
